// File: rtl/booth_issue_ctrl.sv
// Issue/capture controller for the sequential Booth multiplier: accepts operand pairs,
// sequences the multiplier's reset/enable, and returns the product. Option: BOOTH_ZERO_BYPASS_EN.
module booth_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 34
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_x_i,
  input  logic [WIDTH-1:0]     in_y_i,
  output logic [WIDTH-1:0]     mul_x_o,
  output logic [WIDTH-1:0]     mul_y_o,
  output logic                 mul_reset_o,
  output logic                 mul_en_o,
  input  logic [2*WIDTH-1:0]   mul_z_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   out_z_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("booth_issue_ctrl: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [2*WIDTH-1:0] z_q;
  logic               out_valid_q;
  logic               rst_flag_q;
  logic               accept;
  logic               bypass;

  assign accept = (state_q == IDLE) && in_valid_i;

`ifdef BOOTH_ZERO_BYPASS_EN
  // A zero operand makes the product trivially zero, so the multiplier is skipped.
  assign bypass = accept && ((in_x_i == '0) || (in_y_i == '0));
`else
  assign bypass = 1'b0;
`endif

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid_i) state_d = bypass ? HOLD : LOAD;
      LOAD: state_d = RUN;
      RUN:  if (cnt_q == '0) state_d = HOLD;
      HOLD: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; mul_reset also covers the cycle(s) following a reset edge
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    mul_reset_o = (state_q == LOAD) || rst_flag_q;
    mul_en_o    = (state_q == RUN);
    busy_o      = (state_q != IDLE);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LOAD) begin
      cnt_d = CNT_W'(LATENCY - 1);
    end else if ((state_q == RUN) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Datapath: operand latch, down-counter and product capture
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      rst_flag_q  <= 1'b1;
    end else begin
      rst_flag_q <= 1'b0;
      cnt_q      <= cnt_d;
      if (accept && !bypass) begin
        x_q <= in_x_i;
        y_q <= in_y_i;
      end
      if (bypass) begin
        z_q         <= '0;
        out_valid_q <= 1'b1;
      end else if ((state_q == RUN) && (cnt_q == '0)) begin
        z_q         <= mul_z_i;
        out_valid_q <= 1'b1;
      end else if ((state_q == HOLD) && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign mul_x_o     = x_q;
  assign mul_y_o     = y_q;
  assign out_z_o     = z_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Scoreboard bench for booth_issue_ctrl with a behavioural sequential multiplier attached.
// Build with BOOTH_ZERO_BYPASS_EN defined to expect the zero-operand shortcut.
`timescale 1ns/1ps
module tb_booth_issue_ctrl;
  localparam int WIDTH = 32;
  localparam int LAT   = 34;
`ifdef BOOTH_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [WIDTH-1:0]  in_x, in_y, mul_x, mul_y;
  logic              mul_reset, mul_en;
  logic [63:0]       mul_z, out_z;
  logic              out_valid, out_ready, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] z;
    int          due;
    bit          zero_path;
  } exp_t;
  exp_t sb[$];

  booth_issue_ctrl #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
    .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_x_i(in_x), .in_y_i(in_y), .mul_x_o(mul_x), .mul_y_o(mul_y),
    .mul_reset_o(mul_reset), .mul_en_o(mul_en), .mul_z_i(mul_z),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_z_o(out_z), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product becomes visible only after 32 enabled cycles
  logic signed [63:0] m_prod;
  int                 m_cnt;
  always @(posedge clk) begin
    if (mul_reset) begin
      m_prod <= $signed(mul_x) * $signed(mul_y);
      m_cnt  <= 0;
      mul_z  <= '0;
    end else if (mul_en) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt >= 31) mul_z <= m_prod;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks multiplier control since the last accept and checks each product
  int en_cnt = 0, en_first = 0, rst_cnt = 0, rst_cyc = 0, txn = 0;
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0; rst_cnt = 0; prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) begin en_cnt = 0; rst_cnt = 0; end
      if (mul_en) begin
        if (en_cnt == 0) en_first = cyc;
        en_cnt++;
      end
      if (mul_reset) begin rst_cnt++; rst_cyc = cyc; end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_out: got out_z=0x%0h expected no product (cycle %0d)", out_z, cyc);
        end else begin
          if (!prev_valid) begin
            txn++;
            $display("txn %0d: out_z=0x%016h at cycle %0d (due %0d)", txn, out_z, cyc, sb[0].due);
            check("latency", 64'(cyc), 64'(sb[0].due));
            check("product", out_z, sb[0].z);
            if (sb[0].zero_path) begin
              check("bypass_en_cnt", 64'(en_cnt), 64'd0);
              check("bypass_rst_cnt", 64'(rst_cnt), 64'd0);
            end else begin
              check("en_cnt", 64'(en_cnt), 64'(LAT));
              check("en_first", 64'(en_first), 64'(sb[0].due - LAT));
              check("rst_cnt", 64'(rst_cnt), 64'd1);
              check("rst_cyc", 64'(rst_cyc), 64'(sb[0].due - LAT - 1));
            end
          end else begin
            check("hold_stable", out_z, sb[0].z);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [63:0] z,
                      input bit keep, output int acc);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end else begin
      acc = cyc;
      e.zero_path = BYPASS && ((x == 0) || (y == 0));
      e.z = z;
      e.due = acc + (e.zero_path ? 1 : LAT + 2);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vx[6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd2, 32'd524290, 32'd0};
  logic [31:0] vy[6] = '{32'd4, 32'd4, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'd67108868, 32'd67108868};
  logic [63:0] vz[6] = '{64'd8, 64'hFFFF_FFFF_FFFF_FFF8, 64'd28, 64'hFFFF_FFFF_FFFF_FFFA,
                         64'd35184508403720, 64'd0};

  initial begin
    int acc, a1, a2, a3;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_z", out_z, 64'd0);
    check("rst_mul_x", 64'(mul_x), 64'd0);
    check("rst_mul_y", 64'(mul_y), 64'd0);
    check("rst_mul_reset", 64'(mul_reset), 64'd1);
    check("rst_mul_en", 64'(mul_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_mul_reset", 64'(mul_reset), 64'd0);
    @(posedge clk); #1;

    // Directed signed products plus a zero operand
    for (int i = 0; i < 6; i++) begin
      send(vx[i], vy[i], vz[i], 1'b0, acc);
      wait_drain();
    end

    // Back-to-back: in_valid held high across three pairs
    send(32'd3, 32'd5, 64'd15, 1'b1, a1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b1, a2);
    send(32'd100000, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFB_6C20, 1'b0, a3);
    check("b2b_gap1", 64'(a2 - a1), 64'd37);
    check("b2b_gap2", 64'(a3 - a2), 64'd37);
    wait_drain();

    // Backpressure: out_ready low for 10 cycles after out_valid rises
    out_ready = 1'b0;
    send(32'd6, 32'd7, 64'd42, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_x = 32'd9; in_y = 32'd9;
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_mul_x", 64'(mul_x), 64'd6);
      check("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_release_idle", 64'(busy), 64'd0);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Reset during the 5th RUN cycle aborts the operation
    send(32'd5, 32'd5, 64'd25, 1'b0, acc);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_running", 64'(mul_en), 64'd1);
    @(posedge clk); @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_z", out_z, 64'd0);
    check("abort_mul_en", 64'(mul_en), 64'd0);
    check("abort_mul_reset", 64'(mul_reset), 64'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    send(32'd1, 32'd67108868, 64'd67108868, 1'b0, acc);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
